rr_arb4: RTL and testbench
==========================

Name: rr_arb4

Overview:
- Round-robin arbiter for four requesters. Generates the 2-bit select S that drives the 4:1 mux4 data path directly downstream.
- Grants one channel at a time and presents the muxed word as a valid/ready stream.
- Supports multi-beat bursts: a grant stays locked to one channel until a beat flagged last is accepted.

Parameters:
- START, 0, channel index (0-3) with highest priority after reset.
- NCH, 4, number of channels. Fixed at 4; RTL may check that NCH==4.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- req  in  4  per-channel request; must stay high until acked
- last  in  4  per-channel last-beat flag, sampled only for the granted channel
- out_ready  in  1  downstream accepts the current beat
- S  out  2  mux select, registered; index of the granted channel
- grant  out  4  one-hot registered grant, 0 when idle
- out_valid  out  1  beat on mux output is valid, registered
- ack  out  4  one-hot, combinational: grant & {4{out_valid & out_ready}}
- err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (rst_n low at a clk edge):
  - S=0, grant=0, out_valid=0, err=0, state=IDLE, ptr=START.
  - ack is therefore 0.
  - Reset mid-burst aborts the burst silently, with no err.
- ptr is the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4 (2-bit wrap).
- IDLE:
  - If req != 0, pick the first set bit in search order.
  - Next edge: grant=onehot(idx), S=idx, out_valid=1, go to BUSY.
  - Latency from req to out_valid is 1 cycle.
  - If req == 0, stay in IDLE with outputs 0.
- BUSY:
  - Grant is locked. S and grant do not change while out_valid && !out_ready, whatever other requesters do.
  - Transfer when out_ready=1: ack[S] is high that cycle.
    - last[S]=0: stay in BUSY with the same grant. ptr is unchanged.
    - last[S]=1: ptr := S+1 (mod 4). Re-arbitrate in the same cycle over req & ~onehot(S), using the new ptr.
      - If any requester remains, load the new grant at the edge and stay BUSY. There is no bubble cycle.
      - Otherwise go to IDLE with out_valid=0, grant=0. S holds its last value.
- Violation: in BUSY, req[S] drops without an ack that cycle.
  - err pulses for 1 cycle (next edge).
  - Go to IDLE, out_valid=0, grant=0, ptr unchanged.
- Simultaneous requests: exactly one winner, per search order. Losers wait; there is no starvation, because ptr rotates after every completed burst.
- A stall on out_ready=0 is unbounded; all outputs stay stable.
- last is ignored for non-granted channels and when no transfer occurs.
- Invariants:
  - grant is one-hot or zero.
  - out_valid == (grant != 0).
  - When out_valid=1, S == index of grant.

Decomposition:
- Package arb_pkg:
  - NCH=4, SEL_W=2
  - typedef enum logic {IDLE, BUSY} arb_state_t
  - typedef logic [SEL_W-1:0] sel_t
- Sub-module rr_pick4 (combinational):
  - Inputs: req[3:0], ptr sel_t.
  - Outputs: found, idx sel_t.
  - Used for both IDLE arbitration and end-of-burst re-arbitration.

Test Plan:
- Reset and single request: rst_n=0 for 2 cycles, then req=4'b0100, last=4'b0100, out_ready=1.
  - Next cycle: S=2, grant=4'b0100, out_valid=1, ack=4'b0100.
  - Following cycle with req=0: out_valid=0.
- Round-robin: req=4'b1111 held, last=4'b1111, out_ready=1, START=0.
  - Grant sequence is S=0,1,2,3,0 on consecutive cycles, with no bubble.
- Burst lock: req=4'b0011, ch0 sends 3 beats with last=0,0,1, out_ready=1.
  - S=0 for 3 cycles, then S=1 on the next cycle.
  - ptr=1 after the burst, so ch1 wins a tie against a newly asserted ch0.
- Stall stability: grant on ch1, out_ready=0 for 5 cycles while req toggles 4'b1010/4'b1110.
  - S=1, grant=4'b0010, out_valid=1 held all 5 cycles; ack=0.
- Violation: BUSY on ch3 with out_ready=0, then req[3] drops.
  - err=1 for exactly 1 cycle; out_valid=0, state IDLE.
  - Next arbitration starts at the unchanged ptr.
- Reset mid-burst: ch2 mid-burst, rst_n=0 for 1 cycle.
  - Next cycle: out_valid=0, grant=0, S=0, err=0.
  - With req=4'b0101 afterwards, ch0 wins (ptr=START=0).
- Mux check in every case: instantiate mux4 #(6) with d0..d3 = 6'h00, 6'h01, 6'h02, 6'h04, fed by S.
  - Whenever out_valid=1, y must equal d[S].

Source files
------------

// File: rtl/rr_arb4_pkg.sv
// Shared types and helpers for the four-channel round-robin arbiter.
package arb_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [NCH-1:0]   chan_t;

  // One-hot channel vector for a channel index.
  function automatic chan_t onehot(input sel_t idx);
    onehot = chan_t'(4'b0001) << idx;
  endfunction

  // Next channel index in search order, wrapping 3 -> 0.
  function automatic sel_t sel_inc(input sel_t idx);
    sel_inc = idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arb4_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface rr_arb4_if;
  import arb_pkg::*;

  chan_t req;
  chan_t last;
  logic  out_ready;
  sel_t  S;
  chan_t grant;
  logic  out_valid;
  chan_t ack;
  logic  err;

  // Requester / downstream side.
  modport master (
    output req, last, out_ready,
    input  S, grant, out_valid, ack, err
  );

  // Arbiter side.
  modport slave (
    input  req, last, out_ready,
    output S, grant, out_valid, ack, err
  );

endinterface

// File: rtl/mux4.sv
// Downstream 4:1 data-path mux driven by the arbiter select.
module mux4 #(
  parameter int W = 8
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  // Select one of four words.
  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_arb4_chk.sv
// Invariant checker for the arbiter outputs; instantiated alongside the arbiter.
module rr_arb4_chk
  import arb_pkg::*;
(
  input logic  clk,
  input logic  rst_n,
  input sel_t  S,
  input chan_t grant,
  input logic  out_valid
);

  // Grant shape, valid/grant consistency and select/grant agreement.
  always @(posedge clk) begin
    if (rst_n) begin
      a_grant_onehot0: assert ($onehot0(grant))
        else $error("grant not one-hot or zero: %b", grant);
      a_valid_grant: assert (out_valid == (grant != 4'b0000))
        else $error("out_valid %b disagrees with grant %b", out_valid, grant);
      a_sel_grant: assert (!out_valid || (grant == onehot(S)))
        else $error("S %0d disagrees with grant %b", S, grant);
    end
  end

endmodule

// File: rtl/rr_arb4_pick.sv
// Rotating-priority picker: first set request bit starting at ptr, wrapping mod 4.
module rr_pick4
  import arb_pkg::*;
(
  input  chan_t req,
  input  sel_t  ptr,
  output logic  found,
  output sel_t  idx
);

  chan_t rot_s;
  sel_t  off_s;

  // Rotate so that rot_s[k] is the request of channel ptr+k.
  always_comb begin
    rot_s = req;
    case (ptr)
      2'd0:    rot_s = req;
      2'd1:    rot_s = {req[0],   req[3:1]};
      2'd2:    rot_s = {req[1:0], req[3:2]};
      2'd3:    rot_s = {req[2:0], req[3]};
      default: rot_s = req;
    endcase
  end

  // Fixed priority on the rotated vector, then translate back to a channel index.
  always_comb begin
    found = 1'b1;
    off_s = 2'd0;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: begin
        found = 1'b0;
        off_s = 2'd0;
      end
    endcase
    idx = ptr + off_s;
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-channel round-robin arbiter with burst lock and registered select/grant.
module rr_arb4
  import arb_pkg::*;
#(
  parameter int unsigned START = 0,
  parameter int          NCH   = 4
) (
  input logic       clk,
  input logic       rst_n,
  rr_arb4_if.slave  bus
);

  if (NCH != 4) begin : g_nch_chk
    $error("rr_arb4 supports exactly four channels");
  end

  arb_state_t state_r, state_nxt_s;
  sel_t       ptr_r, ptr_nxt_s;
  sel_t       sel_r, sel_nxt_s;
  chan_t      grant_r, grant_nxt_s;
  logic       valid_r, valid_nxt_s;
  logic       err_r, err_nxt_s;

  logic       xfer_s;
  logic       burst_end_s;
  logic       viol_s;
  chan_t      pick_req_s;
  sel_t       pick_ptr_s;
  logic       found_s;
  sel_t       idx_s;

  // Beat accepted this cycle, end of burst, and request dropped mid-grant.
  always_comb begin
    xfer_s      = valid_r & bus.out_ready;
    burst_end_s = 1'b0;
    viol_s      = 1'b0;
    if (state_r == BUSY) begin
      burst_end_s = xfer_s & bus.last[sel_r];
      viol_s      = ~bus.req[sel_r] & ~xfer_s;
    end else begin
      burst_end_s = 1'b0;
      viol_s      = 1'b0;
    end
  end

  // Picker inputs: full request set from ptr when idle, others from S+1 at burst end.
  always_comb begin
    pick_req_s = bus.req;
    pick_ptr_s = ptr_r;
    if (state_r == BUSY) begin
      pick_req_s = bus.req & ~onehot(sel_r);
      pick_ptr_s = sel_inc(sel_r);
    end else begin
      pick_req_s = bus.req;
      pick_ptr_s = ptr_r;
    end
  end

  rr_pick4 u_pick (
    .req   (pick_req_s),
    .ptr   (pick_ptr_s),
    .found (found_s),
    .idx   (idx_s)
  );

  // Next-state logic for the grant FSM and the priority pointer.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    sel_nxt_s   = sel_r;
    grant_nxt_s = grant_r;
    valid_nxt_s = valid_r;
    err_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s = BUSY;
          sel_nxt_s   = idx_s;
          grant_nxt_s = onehot(idx_s);
          valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
          grant_nxt_s = 4'b0000;
          valid_nxt_s = 1'b0;
        end
      end
      BUSY: begin
        if (viol_s) begin
          // Requester abandoned its grant: flag it and drop back without rotating.
          state_nxt_s = IDLE;
          grant_nxt_s = 4'b0000;
          valid_nxt_s = 1'b0;
          err_nxt_s   = 1'b1;
        end else if (burst_end_s) begin
          // Burst done: rotate and hand over in the same cycle, no bubble.
          ptr_nxt_s = sel_inc(sel_r);
          if (found_s) begin
            state_nxt_s = BUSY;
            sel_nxt_s   = idx_s;
            grant_nxt_s = onehot(idx_s);
            valid_nxt_s = 1'b1;
          end else begin
            state_nxt_s = IDLE;
            grant_nxt_s = 4'b0000;
            valid_nxt_s = 1'b0;
          end
        end else begin
          // Stalled or mid-burst: grant stays locked.
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = 4'b0000;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= sel_t'(START);
      sel_r   <= 2'd0;
      grant_r <= 4'b0000;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      sel_r   <= sel_nxt_s;
      grant_r <= grant_nxt_s;
      valid_r <= valid_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign bus.S         = sel_r;
  assign bus.grant     = grant_r;
  assign bus.out_valid = valid_r;
  assign bus.err       = err_r;
  assign bus.ack       = grant_r & {4{xfer_s}};

endmodule

// File: tb/tb_rr_arb4.sv
// Directed table-driven bench for rr_arb4 with the downstream mux4 attached.
module tb_rr_arb4;
  import arb_pkg::*;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    logic       chk;
    logic [1:0] s;
    logic [3:0] g;
    logic       v;
    logic [3:0] a;
    logic       e;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] y;
  int         pass_cnt;
  int         total_cnt;
  vec_t       tbl[$];
  vec_t       seq[$];

  rr_arb4_if bus ();

  rr_arb4 #(.START(0), .NCH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mux4 #(.W(6)) u_mux (
    .d0  (6'h00),
    .d1  (6'h01),
    .d2  (6'h02),
    .d3  (6'h04),
    .sel (bus.S),
    .y   (y)
  );

  rr_arb4_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .S         (bus.S),
    .grant     (bus.grant),
    .out_valid (bus.out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                              input logic rd, input logic c, input logic [1:0] s,
                              input logic [3:0] g, input logic v, input logic [3:0] a,
                              input logic e);
    vec_t t;
    t.rst_n = r; t.req = rq; t.last = ls; t.rdy = rd; t.chk = c;
    t.s = s; t.g = g; t.v = v; t.a = a; t.e = e;
    return t;
  endfunction

  function automatic logic [5:0] mux_ref(input logic [1:0] s);
    case (s)
      2'd0:    return 6'h00;
      2'd1:    return 6'h01;
      2'd2:    return 6'h02;
      default: return 6'h04;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // One cycle: drive inputs after the edge, compare at the falling edge.
  task automatic run_vec(input vec_t t, input string tag);
    rst_n         = t.rst_n;
    bus.req       = t.req;
    bus.last      = t.last;
    bus.out_ready = t.rdy;
    @(negedge clk);
    if (t.chk) begin
      chk({tag, ".S"},         8'(bus.S),         8'(t.s));
      chk({tag, ".grant"},     8'(bus.grant),     8'(t.g));
      chk({tag, ".out_valid"}, 8'(bus.out_valid), 8'(t.v));
      chk({tag, ".ack"},       8'(bus.ack),       8'(t.a));
      chk({tag, ".err"},       8'(bus.err),       8'(t.e));
      if (t.v) chk({tag, ".mux_y"}, 8'(y), 8'(mux_ref(t.s)));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;

    // Reset, then a single request on ch2 that completes in one beat.
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b0));
    // Reset again so round-robin starts from ptr=0; all four request single beats.
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b0));
    // ch0 burst of three beats, ch1 waiting; ch1 takes over with no bubble.
    tbl.push_back(mk(1'b1, 4'b0011, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0011, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0011, 4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b0));
    // Stall on ch1 for five cycles while other requests toggle.
    tbl.push_back(mk(1'b1, 4'b1010, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1110, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1010, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1110, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1010, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1010, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b0));
    // ch3 stalled, then drops its request: one-cycle err, ptr stays at 2.
    tbl.push_back(mk(1'b1, 4'b1000, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b0, 4'b0000, 1'b1));
    tbl.push_back(mk(1'b1, 4'b0111, 4'b0100, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b0, 4'b0000, 1'b0));
    // ch2 wins from ptr=2, sends a non-last beat, then reset aborts the burst.
    tbl.push_back(mk(1'b1, 4'b0111, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0111, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0101, 4'b0101, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0101, 4'b0101, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b0));

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Tie after a burst: ptr=1 lets ch1 beat ch0; ch0's last is ignored while ch1 holds the grant.
    seq.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b0));
    seq.push_back(mk(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0));
    seq.push_back(mk(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b0));
    seq.push_back(mk(1'b1, 4'b0011, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0));
    seq.push_back(mk(1'b1, 4'b0011, 4'b0001, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b0));
    seq.push_back(mk(1'b1, 4'b0011, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b0));
    seq.push_back(mk(1'b1, 4'b0001, 4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 4'b0000, 1'b0));

    foreach (seq[i]) run_vec(seq[i], $sformatf("tie%0d", i));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
